// File: rtl/reaction_pkg.sv
// Shared types and default sizes for the reaction timer and its display stage.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ARMED  = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int MS_W_DEF   = 14;
  localparam int MAX_MS_DEF = 9999;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11; a non-zero seed never reaches zero.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game FSM: random wait, stimulus LED, ms count to react / false start / timeout.
// Optional best-time register enabled by defining REACTION_BEST_EN.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int          MS_W         = MS_W_DEF,
  parameter int          MAX_MS       = MAX_MS_DEF,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_1ms,
  input  logic            start_btn,
  input  logic            react_btn,
  output logic            led_stim,
  output logic            busy,
  output logic [MS_W-1:0] reaction_ms,
  output logic            result_valid,
  output logic            false_start,
`ifdef REACTION_BEST_EN
  output logic [MS_W-1:0] best_ms,
`endif
  output logic            timeout
);

  localparam int DT_W = (MS_W > RAND_BITS + 1) ? MS_W : RAND_BITS + 1;
  localparam logic [MS_W-1:0] MAX_V = MS_W'(MAX_MS);
  localparam logic [DT_W-1:0] MIN_V = DT_W'(MIN_DELAY_MS);

  state_t            state, state_nx;
  logic [15:0]       lfsr;
  logic              unused_lfsr;
  logic [DT_W-1:0]   delay_cnt, delay_cnt_nx, delay_target, delay_target_nx, delay_inc;
  logic [MS_W-1:0]   ms_cnt, ms_cnt_nx, ms_inc, reaction_nx;
  logic              led_nx, busy_nx, valid_nx, false_nx, timeout_nx;

  // Runs every clock so the delay depends on when the player presses start.
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );
  assign unused_lfsr = ^lfsr;

  assign delay_inc = delay_cnt + DT_W'(1);
  assign ms_inc    = ms_cnt + MS_W'(1);

  always_comb begin
    state_nx        = state;
    delay_cnt_nx    = delay_cnt;
    delay_target_nx = delay_target;
    ms_cnt_nx       = ms_cnt;
    reaction_nx     = reaction_ms;
    false_nx        = false_start;
    timeout_nx      = timeout;
    valid_nx        = 1'b0;
    case (state)
      IDLE, RESULT: begin
        if (start_btn) begin
          state_nx        = DELAY;
          delay_target_nx = MIN_V + DT_W'(lfsr[RAND_BITS-1:0]);
          delay_cnt_nx    = '0;
          reaction_nx     = '0;
          false_nx        = 1'b0;
          timeout_nx      = 1'b0;
        end
      end
      DELAY: begin
        // react beats an arming tick in the same cycle
        if (react_btn) begin
          state_nx    = RESULT;
          false_nx    = 1'b1;
          reaction_nx = '0;
          valid_nx    = 1'b1;
        end else if (tick_1ms) begin
          delay_cnt_nx = delay_inc;
          if (delay_inc == delay_target) begin
            state_nx  = ARMED;
            ms_cnt_nx = '0;
          end
        end
      end
      ARMED: begin
        if (react_btn) begin
          state_nx    = RESULT;
          reaction_nx = tick_1ms ? ms_inc : ms_cnt;
          ms_cnt_nx   = reaction_nx;
          valid_nx    = 1'b1;
        end else if (tick_1ms) begin
          ms_cnt_nx = ms_inc;
          if (ms_inc == MAX_V) begin
            state_nx    = RESULT;
            timeout_nx  = 1'b1;
            reaction_nx = MAX_V;
            valid_nx    = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    led_nx  = (state_nx == ARMED);
    busy_nx = (state_nx == DELAY) || (state_nx == ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      delay_cnt    <= '0;
      delay_target <= '0;
      ms_cnt       <= '0;
      reaction_ms  <= '0;
      led_stim     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      delay_cnt    <= delay_cnt_nx;
      delay_target <= delay_target_nx;
      ms_cnt       <= ms_cnt_nx;
      reaction_ms  <= reaction_nx;
      led_stim     <= led_nx;
      busy         <= busy_nx;
      result_valid <= valid_nx;
      false_start  <= false_nx;
      timeout      <= timeout_nx;
    end
  end

`ifdef REACTION_BEST_EN
  // Compared against the registered result during the result_valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_ms <= MAX_V;
    end else if (result_valid && !false_start && !timeout && (reaction_ms < best_ms)) begin
      best_ms <= reaction_ms;
    end
  end
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: randomized rounds, expected results queued, monitor compares.
module tb_reaction_timer;

  localparam int MS_W = 14;
  localparam int MAX_MS = 20;
  localparam int MIN_D = 5;
  localparam int RBITS = 2;

  logic clk = 0, rst_n = 0, tick_1ms = 0, start_btn = 0, react_btn = 0;
  logic led_stim, busy, result_valid, false_start, timeout;
  logic [MS_W-1:0] reaction_ms;
`ifdef REACTION_BEST_EN
  logic [MS_W-1:0] best_ms;
`endif

  reaction_timer #(.MS_W(MS_W), .MAX_MS(MAX_MS), .MIN_DELAY_MS(MIN_D), .RAND_BITS(RBITS),
                   .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms), .start_btn(start_btn), .react_btn(react_btn),
    .led_stim(led_stim), .busy(busy), .reaction_ms(reaction_ms), .result_valid(result_valid),
    .false_start(false_start),
`ifdef REACTION_BEST_EN
    .best_ms(best_ms),
`endif
    .timeout(timeout));

  always #5 clk = ~clk;

  typedef struct { int ms; bit fs; bit to; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int phase = 0;
  int best_model = MAX_MS;
  bit best_chk = 0;

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", name, got, want, $time);
    end
  endtask

  function automatic bit rs();
    return ($urandom_range(0, 7) == 0);
  endfunction

  // One clock: inputs applied at negedge, consumed at posedge, back at next negedge.
  task automatic cyc(input bit st, input bit rc, output bit t);
    t = (phase == 9);
    tick_1ms = t; start_btn = st; react_btn = rc;
    @(posedge clk); @(negedge clk);
    phase = (phase + 1) % 10;
    tick_1ms = 0; start_btn = 0; react_btn = 0;
  endtask

  task automatic start_and_arm();
    bit t; int dt = 0; int n = 0;
    cyc(1, 0, t);
    chk("busy_after_start", busy, 1);
    chk("cleared_ms", reaction_ms, 0);
    chk("cleared_flags", {false_start, timeout}, 0);
    while (!led_stim && n < 200) begin
      cyc(rs(), 0, t);
      if (t) dt++;
      n++;
    end
    chk("arm_seen", led_stim, 1);
    chk("delay_ticks_in_range", (dt >= MIN_D && dt <= MIN_D + (1 << RBITS) - 1), 1);
  endtask

  task automatic post(input exp_t e);
    bit t;
    repeat ($urandom_range(2, 5)) cyc(0, $urandom_range(0, 1), t);
    chk("hold_ms", reaction_ms, e.ms);
    chk("hold_flags", {false_start, timeout}, {e.fs, e.to});
    chk("idle_led_busy", {led_stim, busy}, 0);
  endtask

  // React after k armed ticks, either between ticks or on the next tick.
  task automatic round_react(input int k, input bit on_tick);
    bit t; int at = 0; exp_t e;
    start_and_arm();
    while (at < k) begin cyc(rs(), 0, t); if (t) at++; end
    if (on_tick) begin
      while (phase != 9) cyc(rs(), 0, t);
      at++;
    end else if (phase == 9) begin
      cyc(0, 0, t); at++;
    end
    e = '{ms: at, fs: 0, to: 0};
    q.push_back(e);
    cyc(0, 1, t);
    post(e);
  endtask

  task automatic round_timeout();
    bit t; int at = 0; exp_t e;
    start_and_arm();
    e = '{ms: MAX_MS, fs: 0, to: 1};
    q.push_back(e);
    while (at < MAX_MS) begin cyc(rs(), 0, t); if (t) at++; end
    post(e);
  endtask

  task automatic round_false(input int j, input bit on_tick);
    bit t; int dt = 0; bit led_seen = 0; exp_t e;
    cyc(1, 0, t);
    while (dt < j) begin cyc(rs(), 0, t); if (t) dt++; led_seen |= led_stim; end
    if (on_tick) while (phase != 9) begin cyc(rs(), 0, t); led_seen |= led_stim; end
    e = '{ms: 0, fs: 1, to: 0};
    q.push_back(e);
    cyc(0, 1, t);
    led_seen |= led_stim;
    chk("fs_led_never", led_seen, 0);
    post(e);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {led_stim, busy, result_valid, false_start, timeout, reaction_ms}, 0);
`ifdef REACTION_BEST_EN
    chk({name, "_best"}, best_ms, MAX_MS);
`endif
  endtask

  // Monitor: every result_valid cycle must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
`ifdef REACTION_BEST_EN
        if (best_chk) begin chk("best_after", best_ms, best_model); best_chk = 0; end
`endif
        if (result_valid) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_valid ms=%0d fs=%0d to=%0d @%0t",
                     reaction_ms, false_start, timeout, $time);
          end else begin
            e = q.pop_front();
            chk("res_ms", reaction_ms, e.ms);
            chk("res_false_start", false_start, e.fs);
            chk("res_timeout", timeout, e.to);
            chk("res_led_busy", {led_stim, busy}, 0);
`ifdef REACTION_BEST_EN
            chk("best_before", best_ms, best_model);
            if (!e.fs && !e.to && e.ms < best_model) best_model = e.ms;
            best_chk = 1;
`endif
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    #3 check_all_zero("reset_state");
    @(negedge clk); rst_n = 1;
    repeat (3) cyc(0, 1, t);   // react in IDLE is ignored
    chk("idle_react_ignored", {result_valid, busy, reaction_ms}, 0);

    round_react(7, 0);
    round_react(4, 0);
    round_react(9, 0);

    // Abort mid-ARMED with an asynchronous reset.
    start_and_arm();
    repeat (25) cyc(0, 0, t);
    #2 rst_n = 0;
    #1 check_all_zero("reset_mid_armed");
    best_model = MAX_MS; best_chk = 0;
    @(negedge clk); rst_n = 1;
    phase = 0;

    round_react(7, 0);
    round_react(3, 1);
    round_false(2, 0);
    round_timeout();
    round_react(MAX_MS - 1, 1);

    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 3))
        0: round_react($urandom_range(1, MAX_MS - 1), 0);
        1: round_react($urandom_range(0, MAX_MS - 1), 1);
        2: round_false($urandom_range(0, MIN_D - 1), $urandom_range(0, 1));
        default: round_timeout();
      endcase
    end

    repeat (3) cyc(0, 0, t);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
